instruction_fetch: RTL

Wishbone classic read master that streams 32-bit instruction words from the boot ROM and any other instruction memory into the CPU decode stage. It sits directly upstream of the boot ROM slave and issues sequential word reads starting at a reset vector. Fetched words are buffered in a small prefetch FIFO, together with their addresses, and handed to the consumer over a valid/ready handshake. Redirect (branch/jump) and bus-error handling are in scope.

---
 rtl/instruction_fetch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Wishbone classic read master feeding a small prefetch FIFO of {pc, instruction}
// entries to the decode stage, with redirect flush and sticky bus-fault reporting.
module instruction_fetch #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int unsigned                FIFO_DEPTH    = 2,
  parameter int unsigned                MAX_RETRY     = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [3:0]               sel_o,
  output logic                     we_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  input  logic                     ack_i,
  input  logic                     err_i,
  input  logic                     rty_i,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     fault_o,
  output logic [ADDRESS_WIDTH-1:0] fault_addr_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [ADDRESS_WIDTH-1:0] PC_MASK = ~ADDRESS_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FAULT
  } state_t;

  state_t                   state_q, state_d;
  logic                     stb_q, stb_d;
  logic [ADDRESS_WIDTH-1:0] adr_q;
  logic [CW-1:0]            cnt_q, next_cnt;
  logic [PW-1:0]            rd_q, wr_q;
  logic [RW-1:0]            retry_q;
  logic                     fault_q;
  logic [ADDRESS_WIDTH-1:0] fault_adr_q;
  logic [DATA_WIDTH-1:0]    last_instr_q;
  logic [ADDRESS_WIDTH-1:0] last_pc_q;
  logic [DATA_WIDTH-1:0]    mem_data [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_pc   [FIFO_DEPTH];

  logic valid, retry_max, do_push, do_pop, do_fault, do_retry, space;

  // Redirect squashes every same-edge bus response and pop; err wins over ack.
  always_comb begin
    valid     = (cnt_q != '0);
    retry_max = (retry_q == RW'(MAX_RETRY));
    do_push   = ~redirect_i & stb_q & ack_i & ~err_i;
    do_retry  = ~redirect_i & stb_q & rty_i & ~ack_i & ~err_i & ~retry_max;
    do_fault  = ~redirect_i & stb_q & (err_i | (rty_i & ~ack_i & retry_max));
    do_pop    = ~redirect_i & valid & ready_i;
    next_cnt  = cnt_q + CW'(do_push) - CW'(do_pop);
    space     = (next_cnt < CW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    stb_d   = 1'b0;
    if (redirect_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
          stb_d   = space;
        end
        S_FETCH: begin
          if (do_fault) state_d = S_FAULT;
          else          stb_d   = space;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q       <= RESET_PC & PC_MASK;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      retry_q     <= '0;
      fault_q     <= 1'b0;
      fault_adr_q <= '0;
    end else if (redirect_i) begin
      adr_q       <= redirect_pc_i & PC_MASK;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      retry_q     <= '0;
      fault_q     <= 1'b0;
      fault_adr_q <= '0;
    end else begin
      cnt_q <= next_cnt;
      if (do_push) begin
        wr_q    <= wr_q + PW'(1);
        adr_q   <= adr_q + ADDRESS_WIDTH'(4);
        retry_q <= '0;
      end
      if (do_retry) retry_q <= retry_q + RW'(1);
      if (do_fault) begin
        fault_q     <= 1'b1;
        fault_adr_q <= adr_q;
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_data[wr_q] <= dat_i;
      mem_pc[wr_q]   <= adr_q;
    end
  end

  // Shadow of the displayed head so the outputs freeze when the FIFO empties.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_instr_q <= '0;
      last_pc_q    <= '0;
    end else if (valid) begin
      last_instr_q <= mem_data[rd_q];
      last_pc_q    <= mem_pc[rd_q];
    end
  end

  assign adr_o        = adr_q;
  assign sel_o        = 4'hF;
  assign we_o         = 1'b0;
  assign cyc_o        = stb_q;
  assign stb_o        = stb_q;
  assign valid_o      = valid;
  assign instr_o      = valid ? mem_data[rd_q] : last_instr_q;
  assign pc_o         = valid ? mem_pc[rd_q]   : last_pc_q;
  assign fault_o      = fault_q;
  assign fault_addr_o = fault_adr_q;

endmodule
